// File: rtl/memory_controller_if.sv
// rtl/memory_controller_if.sv - request, response and RAM byte-bus signals of the memory controller
interface memory_controller_if;
    logic        readyIn;
    logic        clearIn;
    logic        ifFlag;
    logic [31:0] ifAddr;
    logic [31:0] ifData;
    logic        ifOkFlag;
    logic        lsbFlag;
    logic [2:0]  lsbOp;
    logic [31:0] lsbAddr;
    logic [31:0] lsbDataOut;
    logic [31:0] lsbDataIn;
    logic        lsbOkFlag;
    logic [7:0]  memIn;
    logic [7:0]  memOut;
    logic [31:0] memAddr;
    logic        memWr;
    logic        ioBufferFull;

    modport slave (
        input  readyIn, clearIn, ifFlag, ifAddr, lsbFlag, lsbOp, lsbAddr, lsbDataOut,
               memIn, ioBufferFull,
        output ifData, ifOkFlag, lsbDataIn, lsbOkFlag, memOut, memAddr, memWr
    );

    modport master (
        output readyIn, clearIn, ifFlag, ifAddr, lsbFlag, lsbOp, lsbAddr, lsbDataOut,
               memIn, ioBufferFull,
        input  ifData, ifOkFlag, lsbDataIn, lsbOkFlag, memOut, memAddr, memWr
    );
endinterface

// File: rtl/memory_controller.sv
// rtl/memory_controller.sv - byte-serial RAM controller for fetch and LSB requests
// MEM_IO_STALL_EN: hold I/O-region store bytes while ioBufferFull is high.
module memory_controller #(
    parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
    input  logic               clockIn,
    input  logic               resetIn,
    memory_controller_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, STORE, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  len_q, len_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] buf_q, buf_d;
    logic        lsb_q, lsb_d;
    logic        store_q, store_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] lsb_data_q, lsb_data_d;

    logic [2:0]  prev_cnt;
    logic [31:0] byte_addr;
    logic [31:0] pend_addr;
    logic        io_hold;
    logic        if_ok, lsb_ok, mem_wr;
    logic        if_ok_out, lsb_ok_out;
    logic [7:0]  mem_out;
    logic [31:0] mem_addr;

    assign prev_cnt  = cnt_q - 3'd1;
    assign byte_addr = addr_q + {29'd0, cnt_q};
    assign pend_addr = addr_q + {29'd0, prev_cnt};

`ifdef MEM_IO_STALL_EN
    assign io_hold = bus.ioBufferFull && (byte_addr >= IO_BASE);
`else
    assign io_hold = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        lsb_d      = lsb_q;
        store_d    = store_q;
        if_data_d  = if_data_q;
        lsb_data_d = lsb_data_q;
        mem_addr   = 32'd0;
        mem_out    = 8'd0;
        mem_wr     = 1'b0;
        if_ok      = 1'b0;
        lsb_ok     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.readyIn && !bus.clearIn) begin
                    cnt_d = 3'd0;
                    if (bus.lsbFlag) begin
                        addr_d  = bus.lsbAddr;
                        lsb_d   = 1'b1;
                        store_d = bus.lsbOp[2];
                        len_d   = bus.lsbOp[1] ? 3'd4 : (bus.lsbOp[0] ? 3'd2 : 3'd1);
                        buf_d   = bus.lsbOp[2] ? bus.lsbDataOut : 32'd0;
                        state_d = bus.lsbOp[2] ? STORE : LOAD;
                    end else if (bus.ifFlag) begin
                        addr_d  = bus.ifAddr;
                        lsb_d   = 1'b0;
                        store_d = 1'b0;
                        len_d   = 3'd4;
                        buf_d   = 32'd0;
                        state_d = FETCH;
                    end
                end
            end
            FETCH, LOAD: begin
                // While frozen, keep the RAM pointed at the byte still owed so memIn is valid on resume.
                mem_addr = (!bus.readyIn && cnt_q != 3'd0) ? pend_addr : byte_addr;
                if (bus.readyIn) begin
                    if (bus.clearIn) begin
                        state_d = IDLE;
                    end else begin
                        if (cnt_q != 3'd0) begin
                            buf_d[{prev_cnt[1:0], 3'b000} +: 8] = bus.memIn;
                        end
                        if (cnt_q == len_q) begin
                            state_d = RESP;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
            end
            STORE: begin
                mem_addr = byte_addr;
                mem_out  = buf_q[{cnt_q[1:0], 3'b000} +: 8];
                mem_wr   = bus.readyIn && !io_hold;
                if (mem_wr) begin
                    if (cnt_q == len_q - 3'd1) begin
                        state_d = RESP;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            RESP: begin
                if (bus.readyIn) begin
                    state_d = IDLE;
                    // A flush drops a finished read, but a store is already in memory and must be acknowledged.
                    if (store_q || !bus.clearIn) begin
                        if (lsb_q) begin
                            lsb_ok = 1'b1;
                            if (!store_q) begin
                                lsb_data_d = buf_q;
                            end
                        end else begin
                            if_ok     = 1'b1;
                            if_data_d = buf_q;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            state_q    <= IDLE;
            addr_q     <= 32'd0;
            len_q      <= 3'd0;
            cnt_q      <= 3'd0;
            buf_q      <= 32'd0;
            lsb_q      <= 1'b0;
            store_q    <= 1'b0;
            if_data_q  <= 32'd0;
            lsb_data_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            lsb_q      <= lsb_d;
            store_q    <= store_d;
            if_data_q  <= if_data_d;
            lsb_data_q <= lsb_data_d;
        end
    end

    assign if_ok_out     = if_ok && !resetIn;
    assign lsb_ok_out    = lsb_ok && !resetIn;
    assign bus.ifOkFlag  = if_ok_out;
    assign bus.lsbOkFlag = lsb_ok_out;
    assign bus.ifData    = if_ok_out ? buf_q : if_data_q;
    assign bus.lsbDataIn = (lsb_ok_out && !store_q) ? buf_q : lsb_data_q;
    assign bus.memAddr   = mem_addr;
    assign bus.memOut    = mem_out;
    assign bus.memWr     = mem_wr && !resetIn;
endmodule
